// File: rtl/neurosa_host_ctrl.sv
`default_nettype none
// neurosa_host_ctrl: host-side master for the neuron array ins/outs/rd/readDone bus.
// Streams count, begin marker and config words, anneals, then captures readouts into a result FIFO.
module neurosa_host_ctrl #(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int COUNT_HOLD      = 2,
  parameter int WORD_HOLD       = 2,
  parameter int RES_DEPTH       = 32,
  parameter int READ_TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start,
  input  logic [NEURON_ID_WIDTH-1:0] n_active,
  input  logic [15:0]                run_cycles,
  input  logic [7:0]                 num_samples,
  input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic [FP_DATA_WIDTH-1:0]   chip_ins,
  output logic                       chip_rd,
  input  logic [FP_DATA_WIDTH-1:0]   chip_outs,
  input  logic                       chip_read_done,
  output logic [FP_DATA_WIDTH-1:0]   res_data,
  output logic                       res_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW  = $clog2(RES_DEPTH);
  localparam int TW  = $clog2(READ_TIMEOUT + 1);
  localparam int WCW = NEURON_ID_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_COUNT, S_SEND_BEGIN, S_LOAD, S_RUN, S_READ_REQ, S_READ, S_DONE
  } state_t;

  state_t                     state, state_d;
  logic [FP_DATA_WIDTH-1:0]   ins_q, ins_d;
  logic [15:0]                hold_q, hold_d;
  logic [WCW-1:0]             words_q, words_d;
  logic [NEURON_ID_WIDTH-1:0] n_q, n_d;
  logic [15:0]                run_q, run_d;
  logic [15:0]                run_cnt_q, run_cnt_d;
  logic [7:0]                 samp_q, samp_d;
  logic [TW-1:0]              to_q, to_d;
  logic                       err_q, err_d;
  logic                       push;

  logic [FP_DATA_WIDTH:0] mem [RES_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   do_push, do_pop;
  logic [31:0]            free_slots, need_slots;

  assign free_slots = 32'(RES_DEPTH) - 32'(count);
  assign need_slots = 32'(n_q >> 4) + 32'd1;

  always_comb begin
    state_d   = state;
    ins_d     = ins_q;
    hold_d    = hold_q;
    words_d   = words_q;
    n_d       = n_q;
    run_d     = run_q;
    run_cnt_d = run_cnt_q;
    samp_d    = samp_q;
    to_d      = to_q;
    err_d     = err_q;
    cfg_ready = 1'b0;
    chip_rd   = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ins_d = '0;
        if (start) begin
          if (n_active == '0) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            n_d     = n_active;
            run_d   = run_cycles;
            samp_d  = num_samples;
            ins_d   = FP_DATA_WIDTH'(n_active);
            hold_d  = 16'(COUNT_HOLD - 1);
            state_d = S_SEND_COUNT;
          end
        end
      end
      S_SEND_COUNT: begin
        if (hold_q == 16'd0) begin
          ins_d   = '1;
          state_d = S_SEND_BEGIN;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_SEND_BEGIN: begin
        ins_d   = '0;
        hold_d  = 16'd0;
        words_d = {n_q, 2'b00};
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hold_q != 16'd0) begin
          hold_d = hold_q - 16'd1;
        end else if (words_q == '0) begin
          ins_d     = '0;
          run_cnt_d = run_q;
          state_d   = S_RUN;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            ins_d   = cfg_data;
            hold_d  = 16'(WORD_HOLD - 1);
            words_d = words_q - WCW'(1);
          end else begin
            // The chip consumes words on a fixed cadence, so a missing word is unrecoverable.
            err_d   = 1'b1;
            ins_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (run_cnt_q != 16'd0) begin
          run_cnt_d = run_cnt_q - 16'd1;
        end else if (free_slots >= need_slots) begin
          state_d = S_READ_REQ;
        end
      end
      S_READ_REQ: begin
        chip_rd = 1'b1;
        to_d    = '0;
        state_d = S_READ;
      end
      S_READ: begin
        chip_rd = !chip_read_done;
        push    = 1'b1;
        if (chip_read_done) begin
          samp_d = (samp_q == 8'd0) ? 8'd0 : samp_q - 8'd1;
          if (samp_q <= 8'd1) begin
            state_d = S_DONE;
          end else begin
            run_cnt_d = run_q;
            state_d   = S_RUN;
          end
        end else if (to_q == TW'(READ_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= S_IDLE;
      ins_q     <= '0;
      hold_q    <= '0;
      words_q   <= '0;
      n_q       <= '0;
      run_q     <= '0;
      run_cnt_q <= '0;
      samp_q    <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      ins_q     <= ins_d;
      hold_q    <= hold_d;
      words_q   <= words_d;
      n_q       <= n_d;
      run_q     <= run_d;
      run_cnt_q <= run_cnt_d;
      samp_q    <= samp_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end

  assign chip_ins = ins_q;
  assign err      = err_q;
  assign busy     = (state != S_IDLE);

  // Full guard only matters when a timed-out read keeps pushing without draining.
  assign do_push   = push && (count != (AW+1)'(RES_DEPTH));
  assign res_valid = (count != '0);
  assign do_pop    = res_valid && res_ready;
  assign res_data  = mem[rd_ptr][FP_DATA_WIDTH-1:0];
  assign res_last  = mem[rd_ptr][FP_DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {chip_read_done, chip_outs};
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule
`default_nettype wire
